// File: rtl/usb_pkg.sv
// Shared USB receive definitions: decoder states, PID codes and CRC16 helpers.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RX_PID,
    RX_DATA,
    RX_HS,
    DRAIN
  } state_t;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

  // Register is kept LSB-first; the residual constant is in polynomial bit order.
  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_crc16.sv
// Byte-wide reflected CRC16 (poly 0x8005) accumulator for received data packets.
module usb_rx_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      crc_out <= CRC16_INIT;
    else if (init)   crc_out <= CRC16_INIT;
    else if (enable) crc_out <= crc16_byte(crc_out, data_in);
  end

endmodule

// File: rtl/usb_packet_decode.sv
// UTMI receive-side decoder: waits for a DATA or handshake packet after a TX, checks PID/CRC,
// streams the payload to the RX FIFO and reports a one-cycle verdict.
module usb_packet_decode
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 816,
  parameter int unsigned MAX_PAYLOAD    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic [7:0] rx_data,
  input  logic       expect_data,
  input  logic       expect_hs,
  input  logic       data_toggle_exp,
  input  logic       rx_fifo_full,
  output logic       rx_wr_en,
  output logic [7:0] rx_wr_data,
  output logic       pkt_commit,
  output logic       pkt_drop,
  output logic       Ack,
  output logic       hs_ack,
  output logic       hs_nak,
  output logic       hs_stall,
  output logic       timeout,
  output logic       pkt_err,
  output logic [6:0] byte_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          exp_data, exp_toggle, pid_toggle;
  logic          overflow, too_long, wrote, hs_extra;
  logic [TW-1:0] tcnt;
  logic [7:0]    hs_pid, dly0, dly1;
  logic [1:0]    fill;
  logic [15:0]   crc;
  logic          crc_init_c, crc_en_c, crc_ok_c, pid_data_c, pid_hs_c;

  always_comb begin
    crc_init_c = (state != RX_DATA);
    crc_en_c   = (state == RX_DATA) && rx_active && rx_valid && !rx_error;
    crc_ok_c   = (bitrev16(crc) == CRC16_RESIDUAL);
    pid_data_c = pid_ok(rx_data) && (rx_data == PID_DATA0 || rx_data == PID_DATA1);
    pid_hs_c   = pid_ok(rx_data) &&
                 (rx_data == PID_ACK || rx_data == PID_NAK || rx_data == PID_STALL);
  end

  usb_rx_crc16 u_crc (
    .clk     (clk),
    .reset   (reset),
    .init    (crc_init_c),
    .enable  (crc_en_c),
    .data_in (rx_data),
    .crc_out (crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      exp_data   <= 1'b0;
      exp_toggle <= 1'b0;
      pid_toggle <= 1'b0;
      overflow   <= 1'b0;
      too_long   <= 1'b0;
      wrote      <= 1'b0;
      hs_extra   <= 1'b0;
      tcnt       <= '0;
      hs_pid     <= '0;
      dly0       <= '0;
      dly1       <= '0;
      fill       <= '0;
      rx_wr_en   <= 1'b0;
      rx_wr_data <= '0;
      pkt_commit <= 1'b0;
      pkt_drop   <= 1'b0;
      Ack        <= 1'b0;
      hs_ack     <= 1'b0;
      hs_nak     <= 1'b0;
      hs_stall   <= 1'b0;
      timeout    <= 1'b0;
      pkt_err    <= 1'b0;
      byte_count <= '0;
    end else begin
      rx_wr_en   <= 1'b0;
      pkt_commit <= 1'b0;
      pkt_drop   <= 1'b0;
      Ack        <= 1'b0;
      hs_ack     <= 1'b0;
      hs_nak     <= 1'b0;
      hs_stall   <= 1'b0;
      timeout    <= 1'b0;
      pkt_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (expect_data || expect_hs) begin
            state      <= ARMED;
            exp_data   <= expect_data;
            exp_toggle <= data_toggle_exp;
            tcnt       <= '0;
            byte_count <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            too_long   <= 1'b0;
            wrote      <= 1'b0;
            hs_extra   <= 1'b0;
          end
        end
        ARMED: begin
          if (rx_active) state <= RX_PID;
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else tcnt <= tcnt + TW'(1);
        end
        RX_PID: begin
          if (rx_error || !rx_active) state <= DRAIN;
          else if (rx_valid) begin
            if (exp_data && pid_data_c) begin
              state      <= RX_DATA;
              pid_toggle <= (rx_data == PID_DATA1);
            end else if (!exp_data && pid_hs_c) begin
              state  <= RX_HS;
              hs_pid <= rx_data;
            end else state <= DRAIN;
          end
        end
        RX_DATA: begin
          if (rx_error) state <= DRAIN;
          else if (!rx_active) begin
            state <= IDLE;
            if (crc_ok_c && fill == 2'd2 && !overflow && !too_long) begin
              Ack <= 1'b1;
              if (pid_toggle == exp_toggle) pkt_commit <= 1'b1;
              else                          pkt_drop   <= 1'b1;
            end else begin
              pkt_drop <= 1'b1;
              pkt_err  <= 1'b1;
            end
          end else if (rx_valid) begin
            // Two-byte delay line: the last two bytes (CRC) never reach the FIFO.
            dly0 <= dly1;
            dly1 <= rx_data;
            if (fill == 2'd2) begin
              if (byte_count >= 7'(MAX_PAYLOAD)) too_long <= 1'b1;
              if (byte_count != 7'h7F) byte_count <= byte_count + 7'd1;
              if (rx_fifo_full) overflow <= 1'b1;
              else begin
                rx_wr_en   <= 1'b1;
                rx_wr_data <= dly0;
                wrote      <= 1'b1;
              end
            end else fill <= fill + 2'd1;
          end
        end
        RX_HS: begin
          if (rx_error) state <= DRAIN;
          else if (!rx_active) begin
            state <= IDLE;
            if (hs_extra) pkt_err <= 1'b1;
            else begin
              hs_ack   <= (hs_pid == PID_ACK);
              hs_nak   <= (hs_pid == PID_NAK);
              hs_stall <= (hs_pid == PID_STALL);
            end
          end else if (rx_valid) hs_extra <= 1'b1;
        end
        DRAIN: begin
          if (!rx_active) begin
            state    <= IDLE;
            pkt_err  <= 1'b1;
            pkt_drop <= wrote;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_packet_decode.md
USB_PACKET_DECODE -- requirements
Module: usb_packet_decode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 816, giving the clk cycles from arming to rx_active rise before a timeout is declared.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 64, giving the maximum accepted data-payload length in bytes.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx_active, rx_valid, rx_error  in  1 each  UTMI receive-side status.
REQ-006 rx_data  in  8  UTMI receive byte, qualified by rx_valid.
REQ-007 expect_data  in  1  one-cycle pulse from the TX encoder: IN token sent, arm for a DATA packet.
REQ-008 expect_hs  in  1  one-cycle pulse from the TX encoder: DATA packet sent, arm for a handshake.
REQ-009 data_toggle_exp  in  1  expected DATA0/DATA1 toggle, sampled with expect_data.
REQ-010 rx_fifo_full  in  1  receive FIFO cannot accept a byte.
REQ-011 rx_wr_en / rx_wr_data  out  1 / 8  payload byte write to the receive FIFO.
REQ-012 pkt_commit, pkt_drop  out  1 each  one-cycle end-of-packet verdict to the FIFO.
REQ-013 Ack  out  1  one-cycle request to the TX encoder to send an ACK.
REQ-014 hs_ack, hs_nak, hs_stall, timeout, pkt_err  out  1 each  one-cycle status pulses to the host controller.
REQ-015 byte_count  out  7  payload length of the last packet, held until the next arming.

Function
REQ-016 States SHALL be: IDLE, ARMED, RX_PID, RX_DATA, RX_HS, DRAIN.
REQ-017 IDLE SHALL go to ARMED on expect_data or expect_hs, latching the expected kind and toggle; if both are high in the same cycle, expect_data wins.
REQ-018 In ARMED, the timeout counter SHALL count from 0; when it reaches TIMEOUT_CYCLES-1 with rx_active low, the block SHALL pulse timeout and return to IDLE.
REQ-019 ARMED SHALL go to RX_PID on rx_active high.
REQ-020 In RX_PID, the first rx_valid byte is the PID; the block SHALL check PID[7:4] == ~PID[3:0].
REQ-021 In RX_PID, a DATA0/DATA1 PID while data is expected SHALL go to RX_DATA; an ACK/NAK/STALL PID while a handshake is expected SHALL go to RX_HS; any other PID, or a failed PID check, SHALL go to DRAIN with error.
REQ-022 RX_DATA SHALL pass bytes through a 2-byte delay line so the two CRC bytes are never written to the FIFO.
REQ-023 In RX_DATA, each rx_valid byte that pushes out a delayed byte SHALL assert rx_wr_en for one cycle, with rx_wr_data equal to that delayed byte.
REQ-024 A running CRC16 (init 0xFFFF, poly 0x8005, reflected) SHALL cover every data byte including the CRC bytes.
REQ-025 On rx_active fall in RX_DATA, the packet is good when the CRC residual is 0x800D, there was no rx_error, no overflow, and the payload length is at most MAX_PAYLOAD.
REQ-026 Verdict latency SHALL be exactly 1 cycle after rx_active falls.
- Good packet with matching toggle: pulse pkt_commit and Ack together.
- Good packet with mismatched toggle: pulse pkt_drop and Ack.
- Bad packet: pulse pkt_drop and pkt_err, with no Ack.
REQ-027 A packet with fewer than 2 bytes after the PID SHALL be treated as bad; a zero-length packet (PID plus 2 CRC bytes) SHALL be good with byte_count 0.
REQ-028 A write while rx_fifo_full is high SHALL suppress rx_wr_en and set the overflow flag.
REQ-029 RX_HS SHALL pulse hs_ack, hs_nak or hs_stall when rx_active falls with no further byte received; otherwise it SHALL pulse pkt_err.
REQ-030 rx_error in any receive state SHALL move the block to DRAIN.
REQ-031 DRAIN SHALL wait for rx_active low, then pulse pkt_err, pulse pkt_drop if any byte was written, and go to IDLE.
REQ-032 expect_* pulses outside IDLE SHALL be ignored.

Reset
REQ-033 Reset SHALL force IDLE; all outputs, counters, flags and the delay line to 0; the CRC register to 0xFFFF.
REQ-034 Reset mid-packet SHALL produce no pkt_commit or pkt_drop; the FIFO is reset by the same signal.

Structure
REQ-035 PID constants, the CRC16 residual and the state enum SHALL live in the shared package usb_pkg.
REQ-036 The CRC16 byte engine SHALL be a single sub-module, usb_rx_crc16, with clk, reset, init, enable, data_in[7:0] and crc_out[15:0].

Verification
REQ-037 expect_data with toggle 0, then DATA0 carrying payload 01 02 03 and its correct CRC: 3 writes of 01/02/03, then pkt_commit and Ack together, byte_count = 3.
REQ-038 Same packet with one CRC bit flipped: 3 writes, then pkt_drop and pkt_err, no Ack.
REQ-039 expect_data with toggle 1, a valid DATA0 arrives: pkt_drop and Ack, no pkt_commit.
REQ-040 expect_hs, then PID 0x5A (NAK): hs_nak pulses once; PID 0xD3 (bad complement): pkt_err.
REQ-041 expect_data with no rx_active: timeout exactly at cycle 816 after arming, state back to IDLE.
REQ-042 rx_fifo_full held during the 2nd payload byte: that write is suppressed, then pkt_drop and pkt_err at end of packet, no Ack.
